// File: rtl/dmem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_read_arbiter
// Brief    : Two-port round-robin read arbiter for the image data ROM with
//            burst streaming, bounds checking and 2-cycle tagged responses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_read_arbiter #(
    parameter int S       = 32,
    parameter int V       = 192,
    parameter int LANES   = 6,
    parameter int SIZE    = 30000,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [S-1:0]       req0_addr,
    input  logic               req0_vec,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [S-1:0]       req1_addr,
    input  logic [BURST_W-1:0] req1_len,
    output logic [S-1:0]       mem_addr,
    output logic               mem_isVector,
    input  logic [V-1:0]       mem_rd,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [V-1:0]       rsp_data,
    output logic               rsp_last,
    output logic               rsp_err
);

    localparam logic [0:0]   c_st_idle    = 1'b0;
    localparam logic [0:0]   c_st_burst   = 1'b1;
    localparam logic [S-1:0] c_lanes      = S'(LANES);
    localparam logic [S-1:0] c_scalar_max = S'(SIZE - 1);
    localparam logic [S-1:0] c_vec_max    = S'(SIZE - LANES);

    logic [0:0]         r_state,     w_state_nxt;
    logic               r_prio,      w_prio_nxt;
    logic [BURST_W-1:0] r_remaining, w_remaining_nxt;
    logic [S-1:0]       r_next_addr, w_next_addr_nxt;
    logic               r_last_beat, w_last_beat_nxt;

    logic               w_issue;
    logic [S-1:0]       w_iss_addr;
    logic               w_iss_vec;
    logic               w_iss_id;
    logic               w_iss_last;
    logic               w_iss_err;

    logic               w_r0_ok;
    logic               w_r1_ok;
    logic               w_nb_ok;
    logic               w_p0_wins;
    logic               w_p1_wins;

    logic               r_s1_valid;
    logic               r_s1_id;
    logic               r_s1_last;
    logic               r_s1_err;

    assign w_r0_ok   = req0_vec ? (req0_addr <= c_vec_max) : (req0_addr <= c_scalar_max);
    assign w_r1_ok   = (req1_addr <= c_vec_max);
    assign w_nb_ok   = (r_next_addr <= c_vec_max);
    assign w_p0_wins = req0_valid & (~req1_valid | ~r_prio);
    assign w_p1_wins = req1_valid & (~req0_valid | r_prio);

    always_comb begin
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        w_issue         = 1'b0;
        w_iss_addr      = '0;
        w_iss_vec       = 1'b0;
        w_iss_id        = 1'b0;
        w_iss_last      = 1'b0;
        w_iss_err       = 1'b0;
        w_state_nxt     = r_state;
        w_prio_nxt      = r_prio;
        w_remaining_nxt = r_remaining;
        w_next_addr_nxt = r_next_addr;
        w_last_beat_nxt = r_last_beat;

        case (r_state)
            c_st_idle: begin
                req0_ready = ~w_p1_wins;
                req1_ready = ~w_p0_wins;
                if (req0_valid && req0_ready) begin
                    w_issue         = 1'b1;
                    w_iss_addr      = req0_addr;
                    w_iss_vec       = req0_vec;
                    w_iss_last      = 1'b1;
                    w_iss_err       = ~w_r0_ok;
                    w_prio_nxt      = 1'b1;
                    w_last_beat_nxt = 1'b0;
                end else if (req1_valid && req1_ready) begin
                    w_prio_nxt = 1'b0;
                    if (req1_len != '0) begin
                        w_issue         = 1'b1;
                        w_iss_addr      = req1_addr;
                        w_iss_vec       = 1'b1;
                        w_iss_id        = 1'b1;
                        w_iss_err       = ~w_r1_ok;
                        w_last_beat_nxt = 1'b1;
                        // Single beat or an out-of-range first beat finishes the burst here
                        if (req1_len == BURST_W'(1) || !w_r1_ok) begin
                            w_iss_last = 1'b1;
                        end else begin
                            w_prio_nxt      = r_prio;
                            w_state_nxt     = c_st_burst;
                            w_remaining_nxt = req1_len - 1'b1;
                            w_next_addr_nxt = req1_addr + c_lanes;
                        end
                    end
                end
            end
            default: begin
                // Port 0 only gets a slot right after a burst beat: 1:1 interleave
                req0_ready = r_last_beat;
                if (req0_valid && r_last_beat) begin
                    w_issue         = 1'b1;
                    w_iss_addr      = req0_addr;
                    w_iss_vec       = req0_vec;
                    w_iss_last      = 1'b1;
                    w_iss_err       = ~w_r0_ok;
                    w_prio_nxt      = 1'b1;
                    w_last_beat_nxt = 1'b0;
                end else begin
                    w_issue         = 1'b1;
                    w_iss_addr      = r_next_addr;
                    w_iss_vec       = 1'b1;
                    w_iss_id        = 1'b1;
                    w_iss_err       = ~w_nb_ok;
                    w_iss_last      = (r_remaining == BURST_W'(1)) | ~w_nb_ok;
                    w_remaining_nxt = r_remaining - 1'b1;
                    w_next_addr_nxt = r_next_addr + c_lanes;
                    w_last_beat_nxt = 1'b1;
                    if (w_iss_last) begin
                        w_state_nxt     = c_st_idle;
                        w_prio_nxt      = 1'b0;
                        w_remaining_nxt = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_prio       <= 1'b0;
            r_remaining  <= '0;
            r_next_addr  <= '0;
            r_last_beat  <= 1'b0;
            mem_addr     <= '0;
            mem_isVector <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_id      <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_err     <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_last     <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_data     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prio      <= w_prio_nxt;
            r_remaining <= w_remaining_nxt;
            r_next_addr <= w_next_addr_nxt;
            r_last_beat <= w_last_beat_nxt;
            if (w_issue) begin
                mem_addr     <= w_iss_err ? '0 : w_iss_addr;
                mem_isVector <= w_iss_vec & ~w_iss_err;
            end
            r_s1_valid <= w_issue;
            r_s1_id    <= w_iss_id;
            r_s1_last  <= w_iss_last;
            r_s1_err   <= w_iss_err;
            rsp_valid  <= r_s1_valid;
            rsp_id     <= r_s1_id;
            rsp_last   <= r_s1_last;
            rsp_err    <= r_s1_err;
            rsp_data   <= (r_s1_valid && !r_s1_err) ? mem_rd : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_read_arbiter
// Brief    : Scoreboard bench for dmem_read_arbiter with a behavioural ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_read_arbiter;

    localparam int S       = 32;
    localparam int V       = 192;
    localparam int LANES   = 6;
    localparam int SIZE    = 30000;
    localparam int BURST_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               req0_valid = 1'b0;
    logic               req0_ready;
    logic [S-1:0]       req0_addr = '0;
    logic               req0_vec = 1'b0;
    logic               req1_valid = 1'b0;
    logic               req1_ready;
    logic [S-1:0]       req1_addr = '0;
    logic [BURST_W-1:0] req1_len = '0;
    logic [S-1:0]       mem_addr;
    logic               mem_isVector;
    logic [V-1:0]       mem_rd;
    logic               rsp_valid;
    logic               rsp_id;
    logic [V-1:0]       rsp_data;
    logic               rsp_last;
    logic               rsp_err;

    dmem_read_arbiter #(
        .S(S), .V(V), .LANES(LANES), .SIZE(SIZE), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_vec(req0_vec),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_len(req1_len),
        .mem_addr(mem_addr), .mem_isVector(mem_isVector), .mem_rd(mem_rd),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [S-1:0] word(input logic [S-1:0] a);
        return (a * 32'h0001_0003) ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [V-1:0] rom_read(input logic [S-1:0] a, input logic vec);
        logic [V-1:0] r;
        r = '0;
        if (vec) begin
            for (int i = 0; i < LANES; i++) r[i*S +: S] = word(a + 32'(i));
        end else begin
            r[S-1:0] = word(a);
        end
        return r;
    endfunction

    always_comb mem_rd = rom_read(mem_addr, mem_isVector);

    typedef struct {
        logic         id;
        logic         last;
        logic         err;
        logic [S-1:0] maddr;
        logic         mvec;
        logic [V-1:0] data;
        int           rel;
    } exp_t;

    exp_t         q[$];
    exp_t         e_mon;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           base = 0;
    logic [S-1:0] prev_addr = '0;
    logic         prev_vec = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: mem_addr seen one cycle before a response is the address that produced it
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected got=id%0d data=%0h want=no_response", rsp_id, rsp_data);
            end else begin
                e_mon = q.pop_front();
                check("rsp_id",       rsp_id,     e_mon.id);
                check("rsp_last",     rsp_last,   e_mon.last);
                check("rsp_err",      rsp_err,    e_mon.err);
                check("rsp_data",     rsp_data,   e_mon.data);
                check("mem_addr",     prev_addr,  e_mon.maddr);
                check("mem_isVector", prev_vec,   e_mon.mvec);
                check("latency",      cyc - base, e_mon.rel);
            end
        end
        prev_addr <= mem_addr;
        prev_vec  <= mem_isVector;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic last, input logic err,
                        input logic [S-1:0] a, input logic vec, input int rel);
        exp_t e;
        e.id    = id;
        e.last  = last;
        e.err   = err;
        e.maddr = err ? '0 : a;
        e.mvec  = err ? 1'b0 : vec;
        e.data  = err ? '0 : rom_read(a, vec);
        e.rel   = rel;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d_pending want=0_pending", q.size());
            q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic single0(input logic [S-1:0] a, input logic vec, input logic err);
        push(1'b0, 1'b1, err, a, vec, 2);
        tick();
        req0_valid = 1'b1;
        req0_addr  = a;
        req0_vec   = vec;
        @(negedge clk);
        check("req0_ready", req0_ready, 1);
        base = cyc;
        tick();
        req0_valid = 1'b0;
        drain();
    endtask

    task automatic burst1(input logic [S-1:0] a, input logic [BURST_W-1:0] len);
        tick();
        req1_valid = 1'b1;
        req1_addr  = a;
        req1_len   = len;
        @(negedge clk);
        check("req1_ready", req1_ready, 1);
        base = cyc;
        tick();
        req1_valid = 1'b0;
    endtask

    task automatic check_all_zero();
        check("rst_rsp_valid", rsp_valid,    0);
        check("rst_rsp_data",  rsp_data,     0);
        check("rst_rsp_id",    rsp_id,       0);
        check("rst_rsp_last",  rsp_last,     0);
        check("rst_rsp_err",   rsp_err,      0);
        check("rst_mem_addr",  mem_addr,     0);
        check("rst_mem_isvec", mem_isVector, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero();
        check("rst_req0_ready", req0_ready, 1);
        check("rst_req1_ready", req1_ready, 1);
        tick();
        reset = 1'b0;

        // Simultaneous requests: port 0 first, then port 1 wins while port 0 stays valid
        push(1'b0, 1'b1, 1'b0, 7,   1'b0, 2);
        push(1'b1, 1'b0, 1'b0, 200, 1'b1, 3);
        push(1'b1, 1'b1, 1'b0, 206, 1'b1, 4);
        tick();
        req0_valid = 1'b1; req0_addr = 7;   req0_vec = 1'b0;
        req1_valid = 1'b1; req1_addr = 200; req1_len = 2;
        @(negedge clk);
        check("both_req0_ready_t0", req0_ready, 1);
        check("both_req1_ready_t0", req1_ready, 0);
        base = cyc;
        tick();
        @(negedge clk);
        check("both_req0_ready_t1", req0_ready, 0);
        check("both_req1_ready_t1", req1_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        single0(10,  1'b0, 1'b0);
        single0(100, 1'b1, 1'b0);

        // Plain burst
        for (int i = 0; i < 4; i++) push(1'b1, i == 3, 1'b0, 32'(6 * i), 1'b1, 2 + i);
        burst1(0, 4);
        drain();

        // Interleave: beat0, req0, beat1, beat2, beat3
        push(1'b1, 1'b0, 1'b0, 0,  1'b1, 2);
        push(1'b0, 1'b1, 1'b0, 50, 1'b0, 3);
        push(1'b1, 1'b0, 1'b0, 6,  1'b1, 4);
        push(1'b1, 1'b0, 1'b0, 12, 1'b1, 5);
        push(1'b1, 1'b1, 1'b0, 18, 1'b1, 6);
        tick();
        req1_valid = 1'b1; req1_addr = 0; req1_len = 4;
        @(negedge clk);
        check("il_req1_ready", req1_ready, 1);
        base = cyc;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 50; req0_vec = 1'b0;
        @(negedge clk);
        check("il_req0_ready_after_beat", req0_ready, 1);
        check("il_req1_ready_in_burst",   req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("il_req0_ready_after_req0", req0_ready, 0);
        drain();

        // len=0 is consumed silently; len=1 is a single last beat
        tick();
        req1_valid = 1'b1; req1_addr = 300; req1_len = 0;
        @(negedge clk);
        check("len0_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        drain();
        push(1'b1, 1'b1, 1'b0, 300, 1'b1, 2);
        burst1(300, 1);
        drain();

        // Bounds edges
        single0(29995, 1'b1, 1'b1);
        single0(29994, 1'b1, 1'b0);
        single0(29999, 1'b0, 1'b0);
        single0(30000, 1'b0, 1'b1);

        push(1'b1, 1'b0, 1'b0, 29982, 1'b1, 2);
        push(1'b1, 1'b0, 1'b0, 29988, 1'b1, 3);
        push(1'b1, 1'b0, 1'b0, 29994, 1'b1, 4);
        push(1'b1, 1'b1, 1'b1, 30000, 1'b1, 5);
        burst1(29982, 5);
        drain();

        // Reset mid-burst: only beats 0 and 1 reach the output before reset
        push(1'b1, 1'b0, 1'b0, 600, 1'b1, 2);
        push(1'b1, 1'b0, 1'b0, 606, 1'b1, 3);
        burst1(600, 10);
        tick();
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_all_zero();
        check("midrst_pending", q.size(), 0);
        tick();
        reset = 1'b0;
        repeat (6) @(negedge clk);

        push(1'b1, 1'b0, 1'b0, 1200, 1'b1, 2);
        push(1'b1, 1'b1, 1'b0, 1206, 1'b1, 3);
        burst1(1200, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
